// File: rtl/spi_sb_pkg.sv
// Shared definitions for the iCE40 SB_SPI system-bus burst reader:
// register map, status bits, chip-select values and FSM state encodings.
package spi_sb_pkg;

  localparam logic [7:0] SPIIRQ  = 8'h06;
  localparam logic [7:0] SPICR2  = 8'h0A;
  localparam logic [7:0] SPISR   = 8'h0C;
  localparam logic [7:0] SPITXDR = 8'h0D;
  localparam logic [7:0] SPIRXDR = 8'h0E;
  localparam logic [7:0] SPICSR  = 8'h0F;

  localparam int SPISR_TRDY = 4;
  localparam int SPISR_RRDY = 3;

  localparam logic [7:0] CS_ASSERT  = 8'hFE;
  localparam logic [7:0] CS_RELEASE = 8'hFF;

  typedef enum logic [3:0] {
    S_IDLE,
    S_REQ,
    S_CS_ON,
    S_TX,
    S_POLL,
    S_RX,
    S_CS_OFF,
    S_RELEASE,
    S_DONE,
    S_ABORT,
    S_ERR
  } rd_state_t;

  typedef enum logic [1:0] {
    T_IDLE,
    T_STB,
    T_ACKLO
  } txn_state_t;

endpackage

// File: rtl/sb_bus_txn.sv
// Single-transaction SB_SPI system-bus master: strobe until ack, then wait
// for ack to fall, with a per-phase timeout.
module sb_bus_txn
  import spi_sb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic       wr,
  input  logic [7:0] adr,
  input  logic [7:0] wdat,
  output logic [7:0] rdat,
  output logic       done,
  output logic       timeout,
  output logic       sb_wr,
  output logic       sb_stb,
  output logic [7:0] sb_adr,
  output logic [7:0] sb_dat_o,
  input  logic [7:0] sb_dat_i,
  input  logic       sb_ack
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  txn_state_t       state;
  txn_state_t       state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic             wait_expired;

  assign wait_expired = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    timeout   = 1'b0;
    case (state)
      T_IDLE: begin
        if (req) state_nxt = T_STB;
      end
      T_STB: begin
        if (sb_ack) begin
          state_nxt = T_ACKLO;
        end else if (wait_expired) begin
          state_nxt = T_IDLE;
          timeout   = 1'b1;
        end
      end
      T_ACKLO: begin
        if (!sb_ack) begin
          state_nxt = T_IDLE;
          done      = 1'b1;
        end else if (wait_expired) begin
          state_nxt = T_IDLE;
          timeout   = 1'b1;
        end
      end
      default: state_nxt = T_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= T_IDLE;
      wait_cnt <= '0;
      sb_stb   <= 1'b0;
      sb_wr    <= 1'b0;
      sb_adr   <= 8'h00;
      sb_dat_o <= 8'h00;
    end else begin
      state <= state_nxt;
      // Each wait phase gets a fresh budget on entry.
      if (state_nxt != state)
        wait_cnt <= '0;
      else if (!wait_expired)
        wait_cnt <= wait_cnt + 1'b1;

      if (state == T_IDLE && req) begin
        sb_stb   <= 1'b1;
        sb_wr    <= wr;
        sb_adr   <= adr;
        sb_dat_o <= wdat;
      end else if (state == T_STB && state_nxt != T_STB) begin
        sb_stb   <= 1'b0;
        sb_wr    <= 1'b0;
        sb_adr   <= 8'h00;
        sb_dat_o <= 8'h00;
      end
    end
  end

  // Read data is captured in the ack cycle; it is data, so no reset.
  always_ff @(posedge clk) begin
    if (state == T_STB && sb_ack)
      rdat <= sb_dat_i;
  end

endmodule

// File: rtl/spi_burst_reader.sv
// SPI burst-read engine: handshakes with the peer, asserts CS, clocks out
// burst_len dummy bytes through SB_SPI and stores each received byte.
module spi_burst_reader
  import spi_sb_pkg::*;
#(
  parameter int         MAX_BYTES      = 35,
  parameter logic [7:0] TX_BYTE        = 8'h81,
  parameter int         TIMEOUT_CYCLES = 4096,
  parameter int         LEN_W          = $clog2(MAX_BYTES + 1),
  parameter int         ADDR_W         = $clog2(MAX_BYTES)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  burst_len,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [LEN_W-1:0]  byte_count,
  output logic              readssr_req,
  input  logic              readssr_ack,
  output logic              sb_wr,
  output logic              sb_stb,
  output logic [7:0]        sb_adr,
  output logic [7:0]        sb_dat_o,
  input  logic [7:0]        sb_dat_i,
  input  logic              sb_ack,
  input  logic [ADDR_W-1:0] buf_raddr,
  output logic [7:0]        buf_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  rd_state_t        state;
  rd_state_t        state_nxt;
  logic [LEN_W-1:0] len_q;
  logic             bad_len_q;
  logic [CNT_W-1:0] wait_cnt;
  logic             wait_expired;
  logic             start_valid;

  logic             txn_req;
  logic             txn_wr;
  logic [7:0]       txn_adr;
  logic [7:0]       txn_wdat;
  logic [7:0]       txn_rdat;
  logic             txn_done;
  logic             txn_timeout;

  logic [7:0]       mem [MAX_BYTES];
  logic [7:0]       rdata_p1;

  assign start_valid  = start && (burst_len != '0) && (burst_len <= LEN_W'(MAX_BYTES));
  assign wait_expired = (wait_cnt >= CNT_W'(TIMEOUT_CYCLES - 1));

  assign busy        = (state != S_IDLE);
  assign done        = (state == S_DONE);
  assign error       = bad_len_q || (state == S_ERR);
  assign readssr_req = state inside {S_REQ, S_CS_ON, S_TX, S_POLL, S_RX, S_CS_OFF, S_ABORT};

  always_comb begin
    state_nxt = state;
    txn_req   = 1'b0;
    txn_wr    = 1'b0;
    txn_adr   = 8'h00;
    txn_wdat  = 8'h00;
    case (state)
      S_IDLE: begin
        if (start_valid) state_nxt = S_REQ;
      end
      S_REQ: begin
        if (readssr_ack)       state_nxt = S_CS_ON;
        else if (wait_expired) state_nxt = S_ABORT;
      end
      S_CS_ON: begin
        txn_req  = 1'b1;
        txn_wr   = 1'b1;
        txn_adr  = SPICSR;
        txn_wdat = CS_ASSERT;
        if (txn_timeout)   state_nxt = S_ABORT;
        else if (txn_done) state_nxt = S_TX;
      end
      S_TX: begin
        txn_req  = 1'b1;
        txn_wr   = 1'b1;
        txn_adr  = SPITXDR;
        txn_wdat = TX_BYTE;
        if (txn_timeout)   state_nxt = S_ABORT;
        else if (txn_done) state_nxt = S_POLL;
      end
      S_POLL: begin
        txn_req = 1'b1;
        txn_adr = SPISR;
        // The poll budget spans all status reads, checked between reads.
        if (txn_timeout) begin
          state_nxt = S_ABORT;
        end else if (txn_done) begin
          if (txn_rdat[SPISR_RRDY]) state_nxt = S_RX;
          else if (wait_expired)    state_nxt = S_ABORT;
        end
      end
      S_RX: begin
        txn_req = 1'b1;
        txn_adr = SPIRXDR;
        if (txn_timeout)                        state_nxt = S_ABORT;
        else if (txn_done && (byte_count + 1'b1 < len_q)) state_nxt = S_TX;
        else if (txn_done)                      state_nxt = S_CS_OFF;
      end
      S_CS_OFF: begin
        txn_req  = 1'b1;
        txn_wr   = 1'b1;
        txn_adr  = SPICSR;
        txn_wdat = CS_RELEASE;
        if (txn_timeout)   state_nxt = S_ABORT;
        else if (txn_done) state_nxt = S_RELEASE;
      end
      S_RELEASE: begin
        // CS is already released here, so a stuck peer goes straight to error.
        if (!readssr_ack)      state_nxt = S_DONE;
        else if (wait_expired) state_nxt = S_ERR;
      end
      S_DONE: state_nxt = S_IDLE;
      S_ABORT: begin
        txn_req  = 1'b1;
        txn_wr   = 1'b1;
        txn_adr  = SPICSR;
        txn_wdat = CS_RELEASE;
        if (txn_done || txn_timeout) state_nxt = S_ERR;
      end
      S_ERR:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      bad_len_q  <= 1'b0;
      wait_cnt   <= '0;
      len_q      <= '0;
      byte_count <= '0;
    end else begin
      state     <= state_nxt;
      bad_len_q <= (state == S_IDLE) && start && !start_valid;
      if (state_nxt != state)
        wait_cnt <= '0;
      else if (!wait_expired)
        wait_cnt <= wait_cnt + 1'b1;

      if (state == S_IDLE && start_valid) begin
        len_q      <= burst_len;
        byte_count <= '0;
      end else if (state == S_RX && txn_done) begin
        byte_count <= byte_count + 1'b1;
      end
    end
  end

  sb_bus_txn #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_txn (
    .clk      (clk),
    .reset    (reset),
    .req      (txn_req),
    .wr       (txn_wr),
    .adr      (txn_adr),
    .wdat     (txn_wdat),
    .rdat     (txn_rdat),
    .done     (txn_done),
    .timeout  (txn_timeout),
    .sb_wr    (sb_wr),
    .sb_stb   (sb_stb),
    .sb_adr   (sb_adr),
    .sb_dat_o (sb_dat_o),
    .sb_dat_i (sb_dat_i),
    .sb_ack   (sb_ack)
  );

  // Buffer write stage: one byte per completed SPIRXDR read
  always_ff @(posedge clk) begin
    if (state == S_RX && txn_done)
      mem[byte_count[ADDR_W-1:0]] <= txn_rdat;
  end

  // Buffer read stage p1: registered, old data on same-cycle write
  always_ff @(posedge clk) begin
    rdata_p1 <= mem[buf_raddr];
  end

  assign buf_rdata = rdata_p1;

endmodule

// File: tb/tb_spi_burst_reader.sv
// Directed bench for spi_burst_reader with a system-bus responder (ack
// latency 2, RRDY on the 3rd status poll) and a readssr peer model.
module tb_spi_burst_reader;

  localparam int MAXB = 35;
  localparam int TO   = 16;
  localparam int LW   = 6;
  localparam int AW   = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [LW-1:0] burst_len;
  logic          busy;
  logic          done;
  logic          error;
  logic [LW-1:0] byte_count;
  logic          readssr_req;
  logic          readssr_ack = 1'b0;
  logic          sb_wr;
  logic          sb_stb;
  logic [7:0]    sb_adr;
  logic [7:0]    sb_dat_o;
  logic [7:0]    sb_dat_i = 8'hEE;
  logic          sb_ack = 1'b0;
  logic [AW-1:0] buf_raddr;
  logic [7:0]    buf_rdata;

  int total = 0;
  int bad   = 0;

  logic       stall_en = 1'b0;
  int         peer_dly = 1;
  logic [7:0] rx_tab [64];

  int         ack_lat = 0;
  int         poll_n = 0;
  int         rx_idx = 0;
  int         log_n = 0;
  logic       log_wr  [512];
  logic [7:0] log_adr [512];
  logic [7:0] log_dat [512];
  int         peer_cnt = 0;
  int         done_cnt = 0;
  int         err_cnt = 0;
  int         stb_cnt = 0;
  int         req_cnt = 0;
  int         busy_cnt = 0;
  int         stb_no_ack = 0;

  always #5 clk = ~clk;

  spi_burst_reader #(
    .MAX_BYTES(MAXB),
    .TX_BYTE(8'h81),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .burst_len(burst_len),
    .busy(busy), .done(done), .error(error), .byte_count(byte_count),
    .readssr_req(readssr_req), .readssr_ack(readssr_ack),
    .sb_wr(sb_wr), .sb_stb(sb_stb), .sb_adr(sb_adr), .sb_dat_o(sb_dat_o),
    .sb_dat_i(sb_dat_i), .sb_ack(sb_ack),
    .buf_raddr(buf_raddr), .buf_rdata(buf_rdata)
  );

  // System-bus responder
  initial forever begin
    @(negedge clk);
    if (!sb_stb) begin
      sb_ack   = 1'b0;
      sb_dat_i = 8'hEE;
      ack_lat  = 0;
    end else if (!sb_ack) begin
      ack_lat++;
      if (ack_lat >= 2 && !(stall_en && sb_adr == 8'h0D)) begin
        sb_ack   = 1'b1;
        sb_dat_i = 8'hEE;
        if (!sb_wr && sb_adr == 8'h0C) begin
          poll_n++;
          sb_dat_i = (poll_n >= 3) ? 8'h18 : 8'h10;
        end else if (!sb_wr && sb_adr == 8'h0E) begin
          sb_dat_i = rx_tab[rx_idx % 64];
          rx_idx++;
        end else if (sb_wr && sb_adr == 8'h0D) begin
          poll_n = 0;
        end
        if (log_n < 512) begin
          log_wr[log_n]  = sb_wr;
          log_adr[log_n] = sb_adr;
          log_dat[log_n] = sb_dat_o;
          log_n++;
        end
      end
    end
  end

  // readssr peer: follows readssr_req after peer_dly cycles
  initial forever begin
    @(negedge clk);
    if (readssr_req != readssr_ack) begin
      peer_cnt++;
      if (peer_cnt >= peer_dly) begin
        readssr_ack = readssr_req;
        peer_cnt    = 0;
      end
    end else begin
      peer_cnt = 0;
    end
  end

  initial forever begin
    @(negedge clk);
    if (done)                    done_cnt++;
    if (error)                   err_cnt++;
    if (sb_stb)                  stb_cnt++;
    if (readssr_req)             req_cnt++;
    if (busy)                    busy_cnt++;
    if (sb_stb && !readssr_ack)  stb_no_ack++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start(input logic [LW-1:0] len);
    burst_len = len;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic wait_end(input int limit, input int d0, input int e0, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done_cnt != d0 || err_cnt != e0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset     = 1'b1;
    start     = 1'b0;
    burst_len = '0;
    buf_raddr = '0;
    tick(3);
    total++; if (busy !== 1'b0)        begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0)        begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (error !== 1'b0)       begin bad++; $display("FAIL reset_error got=%b exp=0", error); end
    total++; if (byte_count !== '0)    begin bad++; $display("FAIL reset_count got=%0d exp=0", byte_count); end
    total++; if (readssr_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", readssr_req); end
    total++; if ({sb_stb, sb_wr} !== 2'b00) begin bad++; $display("FAIL reset_stb_wr got=%b exp=00", {sb_stb, sb_wr}); end
    total++; if ({sb_adr, sb_dat_o} !== 16'h0000) begin bad++; $display("FAIL reset_adr_dat got=%h exp=0000", {sb_adr, sb_dat_o}); end
    reset = 1'b0;
    tick(2);
  endtask

  task automatic test_burst4;
    logic       ok;
    int         d0, e0, l0, r0, n;
    logic [16:0] exp_log [32];
    logic [7:0] exp_rx [4];
    exp_rx[0] = 8'h11; exp_rx[1] = 8'h22; exp_rx[2] = 8'h33; exp_rx[3] = 8'h44;
    d0 = done_cnt; e0 = err_cnt; l0 = log_n; r0 = rx_idx;
    for (int k = 0; k < 4; k++) rx_tab[(r0 + k) % 64] = exp_rx[k];
    n = 0;
    exp_log[n++] = {1'b1, 8'h0F, 8'hFE};
    for (int b = 0; b < 4; b++) begin
      exp_log[n++] = {1'b1, 8'h0D, 8'h81};
      for (int p = 0; p < 3; p++) exp_log[n++] = {1'b0, 8'h0C, 8'h00};
      exp_log[n++] = {1'b0, 8'h0E, 8'h00};
    end
    exp_log[n++] = {1'b1, 8'h0F, 8'hFF};

    pulse_start(6'd4);
    wait_end(600, d0, e0, ok);
    total++; if (ok !== 1'b1)          begin bad++; $display("FAIL b4_finish got=%b exp=1", ok); end
    total++; if (byte_count !== 6'd4)  begin bad++; $display("FAIL b4_count got=%0d exp=4", byte_count); end
    total++; if (log_n - l0 != n)      begin bad++; $display("FAIL b4_txn_count got=%0d exp=%0d", log_n - l0, n); end
    for (int i = 0; i < n; i++) begin
      total++;
      if ({log_wr[l0+i], log_adr[l0+i], log_dat[l0+i]} !== exp_log[i]) begin
        bad++;
        $display("FAIL b4_txn[%0d] got=%h exp=%h", i, {log_wr[l0+i], log_adr[l0+i], log_dat[l0+i]}, exp_log[i]);
      end
    end
    tick(3);
    total++; if (done_cnt - d0 != 1)   begin bad++; $display("FAIL b4_done_pulses got=%0d exp=1", done_cnt - d0); end
    total++; if (err_cnt - e0 != 0)    begin bad++; $display("FAIL b4_errors got=%0d exp=0", err_cnt - e0); end
    total++; if (busy !== 1'b0)        begin bad++; $display("FAIL b4_busy_after got=%b exp=0", busy); end
    for (int i = 0; i < 4; i++) begin
      buf_raddr = AW'(i);
      @(negedge clk);
      total++;
      if (buf_rdata !== exp_rx[i]) begin bad++; $display("FAIL b4_buf[%0d] got=%h exp=%h", i, buf_rdata, exp_rx[i]); end
    end
    tick(4);
  endtask

  task automatic test_bad_len;
    int e0, s0, q0, b0, d0;
    e0 = err_cnt; s0 = stb_cnt; q0 = req_cnt; b0 = busy_cnt; d0 = done_cnt;
    pulse_start(6'd0);
    tick(4);
    total++; if (err_cnt - e0 != 1) begin bad++; $display("FAIL badlen0_err got=%0d exp=1", err_cnt - e0); end
    pulse_start(6'd36);
    tick(4);
    total++; if (err_cnt - e0 != 2) begin bad++; $display("FAIL badlen36_err got=%0d exp=2", err_cnt - e0); end
    total++; if (stb_cnt - s0 != 0) begin bad++; $display("FAIL badlen_stb got=%0d exp=0", stb_cnt - s0); end
    total++; if (req_cnt - q0 != 0) begin bad++; $display("FAIL badlen_req got=%0d exp=0", req_cnt - q0); end
    total++; if (busy_cnt - b0 != 0) begin bad++; $display("FAIL badlen_busy got=%0d exp=0", busy_cnt - b0); end
    total++; if (done_cnt - d0 != 0) begin bad++; $display("FAIL badlen_done got=%0d exp=0", done_cnt - d0); end
  endtask

  task automatic test_timeout;
    logic ok;
    int   d0, e0, l0;
    d0 = done_cnt; e0 = err_cnt; l0 = log_n;
    stall_en = 1'b1;
    pulse_start(6'd2);
    wait_end(300, d0, e0, ok);
    total++; if (ok !== 1'b1)          begin bad++; $display("FAIL to_finish got=%b exp=1", ok); end
    total++; if (err_cnt - e0 != 1)    begin bad++; $display("FAIL to_err got=%0d exp=1", err_cnt - e0); end
    total++; if (done_cnt - d0 != 0)   begin bad++; $display("FAIL to_done got=%0d exp=0", done_cnt - d0); end
    total++; if (readssr_req !== 1'b0) begin bad++; $display("FAIL to_req got=%b exp=0", readssr_req); end
    total++; if (log_n - l0 != 2)      begin bad++; $display("FAIL to_txn_count got=%0d exp=2", log_n - l0); end
    total++;
    if ({log_wr[l0+1], log_adr[l0+1], log_dat[l0+1]} !== {1'b1, 8'h0F, 8'hFF}) begin
      bad++; $display("FAIL to_cs_off got=%h exp=10fff", {log_wr[l0+1], log_adr[l0+1], log_dat[l0+1]});
    end
    tick(1);
    total++; if (busy !== 1'b0)        begin bad++; $display("FAIL to_busy got=%b exp=0", busy); end
    total++; if (sb_stb !== 1'b0)      begin bad++; $display("FAIL to_stb got=%b exp=0", sb_stb); end
    stall_en = 1'b0;
    tick(6);
  endtask

  task automatic test_delayed_ack;
    logic ok;
    int   d0, e0, n0, s0, l0;
    d0 = done_cnt; e0 = err_cnt; n0 = stb_no_ack; s0 = stb_cnt; l0 = log_n;
    peer_dly = 10;
    pulse_start(6'd2);
    tick(3);
    pulse_start(6'd5);
    wait_end(800, d0, e0, ok);
    tick(20);
    total++; if (ok !== 1'b1)           begin bad++; $display("FAIL dly_finish got=%b exp=1", ok); end
    total++; if (done_cnt - d0 != 1)    begin bad++; $display("FAIL dly_done got=%0d exp=1", done_cnt - d0); end
    total++; if (err_cnt - e0 != 0)     begin bad++; $display("FAIL dly_err got=%0d exp=0", err_cnt - e0); end
    total++; if (byte_count !== 6'd2)   begin bad++; $display("FAIL dly_count got=%0d exp=2", byte_count); end
    total++; if (stb_no_ack - n0 != 0)  begin bad++; $display("FAIL dly_early_bus got=%0d exp=0", stb_no_ack - n0); end
    total++; if (stb_cnt - s0 == 0)     begin bad++; $display("FAIL dly_bus_used got=0 exp=nonzero"); end
    total++; if (log_n - l0 != 12)      begin bad++; $display("FAIL dly_txn_count got=%0d exp=12", log_n - l0); end
    total++; if (busy !== 1'b0)         begin bad++; $display("FAIL dly_busy got=%b exp=0", busy); end
    peer_dly = 1;
    tick(4);
  endtask

  task automatic test_reset_midburst;
    logic ok;
    logic found;
    int   d0, e0, r0;
    logic [7:0] ev;
    r0 = rx_idx;
    for (int k = 0; k < 4; k++) rx_tab[(r0 + k) % 64] = 8'(8'hC0 + k);
    pulse_start(6'd4);
    found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (sb_stb && sb_adr == 8'h0E && rx_idx == r0 + 1) begin
        found = 1'b1;
        break;
      end
    end
    total++; if (found !== 1'b1) begin bad++; $display("FAIL rst_reach_rx2 got=%b exp=1", found); end
    reset = 1'b1;
    @(negedge clk);
    total++; if (sb_stb !== 1'b0)      begin bad++; $display("FAIL rst_stb got=%b exp=0", sb_stb); end
    total++; if (readssr_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", readssr_req); end
    total++; if (busy !== 1'b0)        begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    total++; if (byte_count !== '0)    begin bad++; $display("FAIL rst_count got=%0d exp=0", byte_count); end
    reset = 1'b0;
    tick(6);

    r0 = rx_idx;
    for (int k = 0; k < 35; k++) rx_tab[(r0 + k) % 64] = 8'(k * 7 + 3);
    d0 = done_cnt; e0 = err_cnt;
    pulse_start(6'd35);
    wait_end(3000, d0, e0, ok);
    total++; if (ok !== 1'b1)         begin bad++; $display("FAIL max_finish got=%b exp=1", ok); end
    total++; if (done_cnt - d0 != 1)  begin bad++; $display("FAIL max_done got=%0d exp=1", done_cnt - d0); end
    total++; if (byte_count !== 6'd35) begin bad++; $display("FAIL max_count got=%0d exp=35", byte_count); end
    for (int i = 0; i < 35; i += 17) begin
      buf_raddr = AW'(i);
      ev = 8'(i * 7 + 3);
      @(negedge clk);
      total++;
      if (buf_rdata !== ev) begin bad++; $display("FAIL max_buf[%0d] got=%h exp=%h", i, buf_rdata, ev); end
    end
  endtask

  initial begin
    test_reset();
    test_burst4();
    test_bad_len();
    test_timeout();
    test_delayed_ack();
    test_reset_midburst();
    tick(4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_burst_reader.md
# spi_burst_reader

Parametrised SPI burst-read engine that drives the iCE40 SB_SPI hard-IP system bus as master. On `start` it performs the `readssr_req`/`readssr_ack` handshake with the requesting peer and asserts chip select 0 through SPICSR. It then clocks out `burst_len` bytes of `TX_BYTE`, reading each received byte from SPIRXDR into an internal buffer. Received data is read back through a registered port. Bus transactions have timeout protection with abort-to-safe-state.

## Interface
- `MAX_BYTES`, default 35: buffer depth and maximum burst length.
- `TX_BYTE`, default 8'h81: dummy byte written to SPITXDR for every transfer.
- `TIMEOUT_CYCLES`, default 4096: maximum wait for `sb_ack`, SPISR.RRDY or `readssr_ack` per wait.
- `LEN_W`, default $clog2(MAX_BYTES+1): width of the length and count fields.
- `ADDR_W`, default $clog2(MAX_BYTES): width of the buffer address.

Ports (one clock `clk`; reset is synchronous and active-high, port `reset`):
- `clk` in 1: system clock, the same clock as SBCLKi.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle request; ignored while `busy`.
- `burst_len` in LEN_W: bytes to read; sampled on accepted `start`.
- `busy` out 1: high from accepted `start` until `done` or `error`.
- `done` out 1: one-cycle pulse on a successful burst.
- `error` out 1: one-cycle pulse on a bad length or a timeout.
- `byte_count` out LEN_W: bytes stored in the current or last burst.
- `readssr_req` out 1: peer request.
- `readssr_ack` in 1: peer acknowledge.
- `sb_wr` out 1: SBWRi.
- `sb_stb` out 1: SBSTBi.
- `sb_adr` out 8: SBADRi.
- `sb_dat_o` out 8: SBDATi.
- `sb_dat_i` in 8: SBDATo.
- `sb_ack` in 1: SBACKo.
- `buf_raddr` in ADDR_W: buffer read address.
- `buf_rdata` out 8: buffer data, registered, 1-cycle latency.

## Operation
- Reset values: all outputs 0 except `sb_adr`=0 and `sb_dat_o`=0. Buffer contents are not cleared.
- `burst_len`==0 or >`MAX_BYTES` on `start`: one-cycle `error` pulse; no handshake or bus activity; `busy` stays 0.
- State machine:
  - IDLE → REQ on a valid `start`.
  - REQ: raise `readssr_req`; wait for `readssr_ack`.
  - CS_ON: write SPICSR=8'hFE.
  - TX: write SPITXDR=`TX_BYTE`.
  - POLL: read SPISR; repeat until bit3 (RRDY)=1.
  - RX: read SPIRXDR; store the byte at index `byte_count`, then increment `byte_count`.
  - Loop back to TX while `byte_count` < `burst_len`.
  - CS_OFF: write SPICSR=8'hFF.
  - RELEASE: drop `readssr_req`; wait for `readssr_ack`=0.
  - DONE: pulse `done`; go to IDLE.
- Bus transaction (write or read):
  - Drive `sb_stb`=1, `sb_wr`, `sb_adr` and `sb_dat_o` together.
  - Hold them until `sb_ack` is sampled 1.
  - On the next edge, drop `sb_stb`/`sb_wr` and zero `sb_adr`/`sb_dat_o`.
  - Wait for `sb_ack`=0 before the next transaction.
  - Read data is captured from `sb_dat_i` in the cycle `sb_ack` is 1.
- Timeout:
  - The counter restarts at the entry to every wait (ack-high, ack-low, RRDY poll, `readssr_ack` high or low).
  - If a wait reaches `TIMEOUT_CYCLES`: abort, attempt CS_OFF (that write is not itself timed out more than once), drop `readssr_req`, pulse `error`, return to IDLE without waiting for `readssr_ack`.
- `byte_count` holds its value after `done` or `error` until the next accepted `start`, which clears it.
- Buffer: single write port (RX state), independent read port usable at any time. A read of the address written in the same cycle returns the old data.
- Reset mid-burst:
  - Next edge: IDLE, with `sb_stb`, `readssr_req` and `busy` = 0.
  - Chip select is not restored; the software/peer re-initialises.

## Timing
- `start` to `readssr_req`=1: 1 cycle.
- Minimum bus transaction, with `sb_ack` returned one cycle after the strobe: 3 cycles (strobe, ack, ack-low).
- Per byte with immediate RRDY: TX + POLL + RX = 3 transactions.
- `done` asserts in the cycle after `readssr_ack` is sampled 0.
- `buf_rdata` is valid one edge after `buf_raddr`.
- `sb_ack` is only examined in wait states; spurious acks elsewhere are ignored.

## Structure
- Shared package `spi_sb_pkg`:
  - Register addresses: SPICR2 8'h0A, SPISR 8'h0C, SPITXDR 8'h0D, SPIRXDR 8'h0E, SPICSR 8'h0F, SPIIRQ 8'h06.
  - SPISR bit indices: TRDY=4, RRDY=3.
  - CS values: 8'hFE and 8'hFF.
  - State enumeration.
- Sub-module `sb_bus_txn`:
  - Single-transaction system-bus master: `req`, `wr`, `adr`, `wdat` in; `rdat`, `done`, `timeout` out.
  - The FSM sequences it.
- Buffer is an inferred RAM array in the top.

## Test plan
- Bus model with ack latency 2 and RRDY after 3 polls; `burst_len`=4 → writes SPICSR FE, then 4×(TXDR 81, SPISR polls, RXDR reads) returning 11, 22, 33, 44, then SPICSR FF. Required: `done` pulse, `byte_count`=4, `buf_rdata` at addresses 0..3 = 11, 22, 33, 44.
- `burst_len`=0 and `burst_len`=36 → single `error` pulse each, no `sb_stb` and no `readssr_req` ever asserted.
- `sb_ack` held 0 during the TXDR write with `TIMEOUT_CYCLES`=16 → `error` pulse, SPICSR FF write attempted, `readssr_req`=0, `busy`=0.
- `readssr_ack` delayed 10 cycles, and `start` re-pulsed while busy → no bus activity before the ack; the second `start` is ignored; one `done` only.
- `reset` asserted during the 2nd RX read → next cycle `sb_stb`=0, `readssr_req`=0, `busy`=0; a subsequent `burst_len`=35 burst completes with `byte_count`=35.
